l1_cache: RTL and testbench

Unified direct-mapped, write-through, no-write-allocate cache between the `cpu` memory request port and the `imem` backing memory. It is the responder on the CPU side and the initiator on the memory side, using the same request/response signalling on both sides. It serves instruction and data accesses from one array, turns read hits into 1-cycle responses, and exposes hit and miss counters for CPI analysis.

---
 rtl/l1_cache.sv | 168 ++++++++++++++++
 tb/tb_l1_cache.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_cache.sv
// rtl/l1_cache.sv - direct-mapped, write-through, no-write-allocate unified L1 cache
package l1_cache_pkg;
    typedef enum logic {BYTE = 1'b0, WORD = 1'b1} access_size_t;
endpackage

module l1_cache
    import l1_cache_pkg::*;
#(
    parameter int NUM_LINES  = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rd_req_valid_i,
    input  logic                  wr_req_valid_i,
    input  logic                  req_is_instr_i,
    input  logic [ADDR_WIDTH-1:0] address_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  access_size_t          access_size_i,
    output logic                  data_valid_o,
    output logic                  data_is_instr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  mem_rd_req_valid_o,
    output logic                  mem_wr_req_valid_o,
    output logic                  mem_req_is_instr_o,
    output logic [ADDR_WIDTH-1:0] mem_address_o,
    output logic [DATA_WIDTH-1:0] mem_wr_data_o,
    output access_size_t          mem_access_size_o,
    input  logic                  mem_data_valid_i,
    input  logic                  mem_data_is_instr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic [31:0]           hit_count_o,
    output logic [31:0]           miss_count_o
);
    localparam int IDX   = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_WIDTH - IDX - 2;

    typedef enum logic [2:0] {IDLE, MISS_REQ, MISS_WAIT, WR_REQ, WR_WAIT, RESP} state_t;

    state_t                state;
    logic [NUM_LINES-1:0]  line_valid;
    logic [TAG_W-1:0]      line_tag  [NUM_LINES];
    logic [DATA_WIDTH-1:0] line_data [NUM_LINES];

    logic [ADDR_WIDTH-1:0] req_addr;
    access_size_t          req_size;

    logic [IDX-1:0]   in_idx, req_idx;
    logic [TAG_W-1:0] in_tag, req_tag;
    logic             in_hit, req_hit;

    // Response direction is implied by the latched request, so the memory-side echo is not needed.
    logic unused_mem_instr;
    assign unused_mem_instr = mem_data_is_instr_i;

    assign in_idx  = address_i[IDX+1:2];
    assign in_tag  = address_i[ADDR_WIDTH-1:IDX+2];
    assign req_idx = req_addr[IDX+1:2];
    assign req_tag = req_addr[ADDR_WIDTH-1:IDX+2];
    assign in_hit  = line_valid[in_idx] && (line_tag[in_idx] == in_tag);
    assign req_hit = line_valid[req_idx] && (line_tag[req_idx] == req_tag);

    function automatic logic [DATA_WIDTH-1:0] read_view(input logic [DATA_WIDTH-1:0] w,
                                                        input logic [1:0] lane,
                                                        input access_size_t sz);
        if (sz == WORD)
            return w;
        return {{(DATA_WIDTH-8){1'b0}}, w[{lane, 3'b000} +: 8]};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old,
                                                    input logic [DATA_WIDTH-1:0] wdata,
                                                    input logic [1:0] lane,
                                                    input access_size_t sz);
        logic [DATA_WIDTH-1:0] r;
        r = old;
        if (sz == WORD)
            r = wdata;
        else
            r[{lane, 3'b000} +: 8] = wdata[7:0];
        return r;
    endfunction

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state              <= IDLE;
            line_valid         <= '0;
            req_addr           <= '0;
            req_size           <= BYTE;
            data_valid_o       <= 1'b0;
            data_is_instr_o    <= 1'b0;
            data_o             <= '0;
            mem_rd_req_valid_o <= 1'b0;
            mem_wr_req_valid_o <= 1'b0;
            mem_req_is_instr_o <= 1'b0;
            mem_address_o      <= '0;
            mem_wr_data_o      <= '0;
            mem_access_size_o  <= BYTE;
            hit_count_o        <= '0;
            miss_count_o       <= '0;
        end else begin
            mem_rd_req_valid_o <= 1'b0;
            mem_wr_req_valid_o <= 1'b0;
            data_valid_o       <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_req_valid_i) begin
                        req_addr           <= address_i;
                        req_size           <= access_size_i;
                        mem_req_is_instr_o <= req_is_instr_i;
                        mem_address_o      <= address_i;
                        mem_wr_data_o      <= wr_data_i;
                        mem_access_size_o  <= access_size_i;
                        mem_wr_req_valid_o <= 1'b1;
                        state              <= WR_REQ;
                    end else if (rd_req_valid_i && in_hit) begin
                        data_valid_o    <= 1'b1;
                        data_is_instr_o <= req_is_instr_i;
                        data_o          <= read_view(line_data[in_idx], address_i[1:0], access_size_i);
                        hit_count_o     <= hit_count_o + 32'd1;
                        state           <= RESP;
                    end else if (rd_req_valid_i) begin
                        req_addr           <= address_i;
                        req_size           <= access_size_i;
                        mem_req_is_instr_o <= req_is_instr_i;
                        mem_address_o      <= {address_i[ADDR_WIDTH-1:2], 2'b00};
                        mem_access_size_o  <= WORD;
                        mem_rd_req_valid_o <= 1'b1;
                        miss_count_o       <= miss_count_o + 32'd1;
                        state              <= MISS_REQ;
                    end
                end
                MISS_REQ: state <= MISS_WAIT;
                MISS_WAIT: begin
                    if (mem_data_valid_i) begin
                        line_valid[req_idx] <= 1'b1;
                        data_valid_o        <= 1'b1;
                        data_is_instr_o     <= mem_req_is_instr_o;
                        data_o              <= read_view(mem_data_i, req_addr[1:0], req_size);
                        state               <= RESP;
                    end
                end
                WR_REQ: state <= WR_WAIT;
                WR_WAIT: begin
                    if (mem_data_valid_i) begin
                        data_valid_o    <= 1'b1;
                        data_is_instr_o <= mem_req_is_instr_o;
                        data_o          <= '0;
                        state           <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Tag/data storage needs no reset; the valid bits gate every use.
    always_ff @(posedge clk_i) begin
        if (state == MISS_WAIT && mem_data_valid_i) begin
            line_tag[req_idx]  <= req_tag;
            line_data[req_idx] <= mem_data_i;
        end else if (state == WR_WAIT && mem_data_valid_i && req_hit) begin
            line_data[req_idx] <= merge(line_data[req_idx], mem_wr_data_o, req_addr[1:0], req_size);
        end
    end
endmodule

// File: tb/tb_l1_cache.sv
// tb/tb_l1_cache.sv - self-checking bench for l1_cache with a behavioural cache/memory model
module tb_l1_cache;
    import l1_cache_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rd_req = 1'b0, wr_req = 1'b0, req_instr = 1'b0;
    logic [31:0]  address = '0, wr_data = '0;
    access_size_t access_size = WORD;
    logic         data_valid, data_is_instr;
    logic [31:0]  data;
    logic         mem_rd_req, mem_wr_req, mem_req_instr;
    logic [31:0]  mem_address, mem_wr_data;
    access_size_t mem_access_size;
    logic         mem_data_valid = 1'b0, mem_data_instr = 1'b0;
    logic [31:0]  mem_data = '0;
    logic [31:0]  hit_count, miss_count;

    always #5 clk = ~clk;

    l1_cache #(.NUM_LINES(16), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .rd_req_valid_i(rd_req), .wr_req_valid_i(wr_req), .req_is_instr_i(req_instr),
        .address_i(address), .wr_data_i(wr_data), .access_size_i(access_size),
        .data_valid_o(data_valid), .data_is_instr_o(data_is_instr), .data_o(data),
        .mem_rd_req_valid_o(mem_rd_req), .mem_wr_req_valid_o(mem_wr_req),
        .mem_req_is_instr_o(mem_req_instr), .mem_address_o(mem_address),
        .mem_wr_data_o(mem_wr_data), .mem_access_size_o(mem_access_size),
        .mem_data_valid_i(mem_data_valid), .mem_data_is_instr_i(mem_data_instr),
        .mem_data_i(mem_data),
        .hit_count_o(hit_count), .miss_count_o(miss_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: 16 one-word lines, index = word address mod 16, tag = address / 64.
    bit          ref_valid [16];
    logic [25:0] ref_tag   [16];
    logic [31:0] ref_data  [16];
    logic [31:0] ref_hits, ref_misses;
    logic [31:0] mem_model [int unsigned];

    function automatic logic [31:0] mem_word(input int unsigned wa);
        if (mem_model.exists(wa))
            return mem_model[wa];
        return (wa * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    function automatic logic [31:0] write_word(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [1:0] lane, input access_size_t sz);
        int sh;
        if (sz == WORD)
            return wd;
        sh = 8 * lane;
        return (old & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
        ref_hits   = 0;
        ref_misses = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rd_req = 1'b0; wr_req = 1'b0; mem_data_valid = 1'b0;
        #1;
        check("rst_data_valid", data_valid, 0);
        check("rst_data", data, 0);
        check("rst_mem_req", {mem_rd_req, mem_wr_req, mem_req_instr, data_is_instr}, 0);
        check("rst_mem_addr", mem_address, 0);
        check("rst_mem_wdata", mem_wr_data, 0);
        check("rst_hits", hit_count, 0);
        check("rst_misses", miss_count, 0);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One CPU access driven from a negedge; returns at a negedge after the response pulse.
    task automatic access(input bit wr, input bit both, input logic [31:0] a, input logic [31:0] wd,
                          input access_size_t sz, input bit instr, output logic [31:0] rdata);
        int unsigned  wa;
        int           idx, mem_reqs, resp_cyc, got_cyc, cnt;
        logic [25:0]  tg;
        bit           hit, pend;
        logic [31:0]  word, exp_data, seen_addr, seen_wdata;
        logic         seen_wr, seen_instr, got_instr;
        access_size_t seen_size;

        wa = a[31:2]; idx = a[5:2]; tg = a[31:6];
        hit = !wr && ref_valid[idx] && ref_tag[idx] == tg;
        mem_reqs = 0; resp_cyc = -1; got_cyc = -1; cnt = 0; pend = 0;
        rdata = 'x; got_instr = 1'bx;
        seen_addr = 'x; seen_wdata = 'x; seen_wr = 1'bx; seen_instr = 1'bx; seen_size = BYTE;
        if (wr) begin
            exp_data = 0;
            mem_model[wa] = write_word(mem_word(wa), wd, a[1:0], sz);
            if (ref_valid[idx] && ref_tag[idx] == tg)
                ref_data[idx] = write_word(ref_data[idx], wd, a[1:0], sz);
        end else begin
            word = hit ? ref_data[idx] : mem_word(wa);
            exp_data = (sz == WORD) ? word : ((word >> (8 * a[1:0])) & 32'hFF);
            if (hit) ref_hits++;
            else begin
                ref_misses++;
                ref_valid[idx] = 1'b1; ref_tag[idx] = tg; ref_data[idx] = word;
            end
        end

        wr_req = wr; rd_req = !wr || both; address = a; wr_data = wd;
        access_size = sz; req_instr = instr;
        @(negedge clk);
        rd_req = 1'b0; wr_req = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (got_cyc >= 0) begin
                check("resp_single_pulse", data_valid, 0);
                break;
            end
            mem_data_valid = 1'b0;
            if (mem_rd_req || mem_wr_req) begin
                mem_reqs++;
                seen_addr = mem_address; seen_wr = mem_wr_req; seen_size = mem_access_size;
                seen_wdata = mem_wr_data; seen_instr = mem_req_instr;
                pend = 1; cnt = $urandom_range(0, 3);
            end else if (pend) begin
                if (cnt == 0) begin
                    mem_data_valid = 1'b1;
                    mem_data_instr = seen_instr;
                    mem_data = seen_wr ? $urandom : mem_word(seen_addr[31:2]);
                    pend = 0; resp_cyc = c;
                end else cnt--;
            end
            if (data_valid) begin
                got_cyc = c; rdata = data; got_instr = data_is_instr;
            end
            @(negedge clk);
        end
        mem_data_valid = 1'b0;

        check("resp_seen", got_cyc >= 0, 1);
        check("data", rdata, exp_data);
        check("data_is_instr", got_instr, instr);
        if (hit) begin
            check("hit_no_mem_req", mem_reqs, 0);
            check("hit_latency", got_cyc, 0);
        end else begin
            check("mem_req_count", mem_reqs, 1);
            check("mem_req_is_write", seen_wr, wr);
            check("mem_addr", seen_addr, wr ? a : {a[31:2], 2'b00});
            check("mem_size", seen_size, wr ? sz : WORD);
            check("mem_instr", seen_instr, instr);
            if (wr) check("mem_wdata", seen_wdata, wd);
            check("miss_latency", got_cyc, resp_cyc + 1);
        end
        check("hit_count", hit_count, ref_hits);
        check("miss_count", miss_count, ref_misses);
    endtask

    logic [31:0] r;

    initial begin
        clear_model();
        @(negedge clk);
        do_reset();

        // Cold miss then hit on 0x4.
        mem_model[1] = 32'h000446F1;
        access(0, 0, 32'h4, 0, WORD, 0, r);
        check("plan_cold_data", r, 32'h000446F1);
        check("plan_cold_miss", miss_count, 1);
        access(0, 0, 32'h4, 0, WORD, 0, r);
        check("plan_rehit_count", hit_count, 1);

        // 0x8 and 0x48 share an index.
        access(0, 0, 32'h8, 0, WORD, 0, r);
        access(0, 0, 32'h48, 0, WORD, 1, r);
        access(0, 0, 32'h8, 0, WORD, 0, r);
        check("plan_evict_misses", miss_count, 4);

        // Write-through with byte merge on a cached line.
        access(1, 0, 32'h8, 32'hDEADBEEF, WORD, 0, r);
        access(1, 0, 32'hA, 32'h00000055, BYTE, 0, r);
        access(0, 0, 32'h8, 0, WORD, 0, r);
        check("plan_merge_data", r, 32'hDE55BEEF);
        check("plan_merge_hits", hit_count, 2);

        // No write allocate.
        access(1, 0, 32'h100, 32'h12345678, WORD, 0, r);
        access(0, 0, 32'h100, 0, WORD, 0, r);
        check("plan_noalloc_misses", miss_count, 5);

        // Reset while waiting on a miss; a stale response afterwards must be dropped.
        rd_req = 1'b1; address = 32'h200; access_size = WORD; req_instr = 1'b0;
        @(negedge clk);
        rd_req = 1'b0;
        check("midrst_mem_req", mem_rd_req, 1);
        @(negedge clk);
        do_reset();
        mem_data_valid = 1'b1; mem_data = 32'hBAD0BAD0;
        @(negedge clk);
        mem_data_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("midrst_no_resp", data_valid, 0);
            @(negedge clk);
        end
        check("midrst_counters", {hit_count, miss_count} == 64'd0, 1);
        access(0, 0, 32'h200, 0, WORD, 0, r);
        check("midrst_line_invalid", miss_count, 1);

        // Byte read from lane 3 of an instruction word.
        mem_model[1] = 32'h11223344;
        access(0, 0, 32'h7, 0, BYTE, 1, r);
        check("plan_byte_read", r, 32'h00000011);

        // Randomized mix over 4 tags x 16 indices.
        for (int n = 0; n < 250; n++) begin
            logic [31:0] a;
            bit          w;
            a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            w = ($urandom_range(0, 2) == 0);
            access(w, w && $urandom_range(0, 1) == 1, a, $urandom,
                   access_size_t'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
